// File: rtl/regn_pkg.sv
// Shared mode encodings for the multimode register.
package regn_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_LOAD  = 2'b00,
        MODE_INC   = 2'b01,
        MODE_DEC   = 2'b10,
        MODE_SHIFT = 2'b11
    } mode_t;

endpackage

// File: rtl/regn_next_calc.sv
// Combinational next-value and overflow logic for the multimode register.
module regn_next_calc
    import regn_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP     = 1,
    parameter bit          SATURATE = 1'b0,
    parameter bit          ROTATE   = 1'b0
) (
    input  logic [WIDTH-1:0]  out,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  in,
    input  logic              en,
    output logic [WIDTH-1:0]  out_next,
    output logic              ovf_next
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           fill;

    // One extra bit catches the carry out of INC and the borrow out of DEC.
    assign sum  = {1'b0, out} + {1'b0, STEP_W};
    assign diff = {1'b0, out} - {1'b0, STEP_W};
    assign fill = ROTATE ? out[WIDTH-1] : in[0];

    always_comb begin
        out_next = out;
        ovf_next = 1'b0;
        if (en) begin
            case (mode_t'(mode))
                MODE_LOAD: out_next = in;
                MODE_INC: begin
                    ovf_next = sum[WIDTH];
                    out_next = (sum[WIDTH] && SATURATE) ? '1 : sum[WIDTH-1:0];
                end
                MODE_DEC: begin
                    ovf_next = diff[WIDTH];
                    out_next = (diff[WIDTH] && SATURATE) ? '0 : diff[WIDTH-1:0];
                end
                MODE_SHIFT: begin
                    out_next = {out[WIDTH-2:0], fill};
                    ovf_next = ROTATE ? 1'b0 : out[WIDTH-1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/regn_multimode.sv
// N-bit register with load / increment / decrement / shift modes and tc/ovf flags.
module regn_multimode
    import regn_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP     = 1,
    parameter bit          SATURATE = 1'b0,
    parameter bit          ROTATE   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in,
    input  logic [MODE_W-1:0] mode_sel,
    input  logic              mode_wr,
    input  logic              en,
    output logic [WIDTH-1:0]  out,
    output logic [MODE_W-1:0] mode,
    output logic              tc,
    output logic              ovf
);

    mode_t            mode_q;
    mode_t            mode_next;
    logic [WIDTH-1:0] out_next;
    logic             ovf_next;

    regn_next_calc #(
        .WIDTH    (WIDTH),
        .STEP     (STEP),
        .SATURATE (SATURATE),
        .ROTATE   (ROTATE)
    ) u_next_calc (
        .out      (out),
        .mode     (mode_q),
        .in       (in),
        .en       (en),
        .out_next (out_next),
        .ovf_next (ovf_next)
    );

    // Mode FSM: a write may target any mode, including the current one.
    always_comb begin
        mode_next = mode_q;
        if (mode_wr) begin
            mode_next = mode_t'(mode_sel);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_LOAD;
            out    <= '0;
            ovf    <= 1'b0;
        end else begin
            mode_q <= mode_next;
            out    <= out_next;
            ovf    <= ovf_next;
        end
    end

    assign mode = mode_q;

    // Terminal count tracks the register directly, no extra cycle.
    always_comb begin
        tc = 1'b0;
        if ((mode_q == MODE_INC) && (out == '1)) begin
            tc = 1'b1;
        end else if ((mode_q == MODE_DEC) && (out == '0)) begin
            tc = 1'b1;
        end
    end

endmodule

// File: tb/tb_regn_multimode.sv
// Scoreboard bench for regn_multimode: default, saturating (STEP=3) and rotating instances.
module tb_regn_multimode;
    import regn_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in;
    logic [1:0] mode_sel;
    logic       mode_wr;
    logic       en;

    logic [7:0] out_a, out_s, out_r;
    logic [1:0] mode_a, mode_s, mode_r;
    logic       tc_a, tc_s, tc_r;
    logic       ovf_a, ovf_s, ovf_r;

    always #5 clk = ~clk;

    regn_multimode dut_a (
        .clk(clk), .rst(rst), .in(in), .mode_sel(mode_sel), .mode_wr(mode_wr), .en(en),
        .out(out_a), .mode(mode_a), .tc(tc_a), .ovf(ovf_a)
    );

    regn_multimode #(.WIDTH(8), .STEP(3), .SATURATE(1'b1), .ROTATE(1'b0)) dut_s (
        .clk(clk), .rst(rst), .in(in), .mode_sel(mode_sel), .mode_wr(mode_wr), .en(en),
        .out(out_s), .mode(mode_s), .tc(tc_s), .ovf(ovf_s)
    );

    regn_multimode #(.WIDTH(8), .STEP(1), .SATURATE(1'b0), .ROTATE(1'b1)) dut_r (
        .clk(clk), .rst(rst), .in(in), .mode_sel(mode_sel), .mode_wr(mode_wr), .en(en),
        .out(out_r), .mode(mode_r), .tc(tc_r), .ovf(ovf_r)
    );

    typedef struct {
        string      name;
        int         d;
        logic [7:0] out;
        logic [1:0] mode;
        logic       tc;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void push_exp(string n, int d, logic [7:0] o, logic [1:0] m,
                                     logic t, logic v);
        exp_t e;
        e.name = n; e.d = d; e.out = o; e.mode = m; e.tc = t; e.ovf = v;
        exp_q.push_back(e);
    endfunction

    function automatic exp_t observe(int d);
        exp_t o;
        o.name = "";
        o.d    = d;
        case (d)
            1:       begin o.out = out_s; o.mode = mode_s; o.tc = tc_s; o.ovf = ovf_s; end
            2:       begin o.out = out_r; o.mode = mode_r; o.tc = tc_r; o.ovf = ovf_r; end
            default: begin o.out = out_a; o.mode = mode_a; o.tc = tc_a; o.ovf = ovf_a; end
        endcase
        return o;
    endfunction

    task automatic drive(logic [7:0] i, logic [1:0] s, logic w, logic e);
        in = i; mode_sel = s; mode_wr = w; en = e;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e, o;
        drive(8'h00, MODE_LOAD, 1'b0, 1'b0);
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: push_exp("reset_initial", 0, 8'h00, MODE_LOAD, 1'b0, 1'b0);
                1: begin
                    tick();
                    rst = 1'b0;
                    drive(8'h37, MODE_LOAD, 1'b0, 1'b1); tick();
                    push_exp("reset_pre_load", 0, 8'h37, MODE_LOAD, 1'b0, 1'b0);
                end
                2: begin
                    drive(8'h00, MODE_INC, 1'b1, 1'b0); tick();
                    push_exp("reset_pre_mode", 0, 8'h37, MODE_INC, 1'b0, 1'b0);
                end
                3: begin
                    #2 rst = 1'b1;
                    #1 push_exp("reset_async", 0, 8'h00, MODE_LOAD, 1'b0, 1'b0);
                end
                4: begin
                    drive(8'hFF, MODE_INC, 1'b1, 1'b1); tick();
                    push_exp("reset_held", 0, 8'h00, MODE_LOAD, 1'b0, 1'b0);
                end
                default: begin
                    @(negedge clk);
                    rst = 1'b0;
                    drive(8'hA5, MODE_LOAD, 1'b0, 1'b1); tick();
                    push_exp("reset_then_load", 0, 8'hA5, MODE_LOAD, 1'b0, 1'b0);
                end
            endcase
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); o = observe(e.d); n_tests++;
                if ({o.out, o.mode, o.tc, o.ovf} !== {e.out, e.mode, e.tc, e.ovf}) begin
                    n_fail++;
                    $display("FAIL %s: got out=%h mode=%0d tc=%b ovf=%b, want out=%h mode=%0d tc=%b ovf=%b",
                             e.name, o.out, o.mode, o.tc, o.ovf, e.out, e.mode, e.tc, e.ovf);
                end
            end
        end
    endtask

    task automatic test_inc_wrap();
        exp_t e, o;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(8'h00, MODE_LOAD, 1'b1, 1'b0);
                1: begin
                    drive(8'hFE, MODE_INC, 1'b1, 1'b1);
                    push_exp("inc_load_old_mode", 0, 8'hFE, MODE_INC, 1'b0, 1'b0);
                end
                2: begin
                    drive(8'h00, MODE_INC, 1'b0, 1'b1);
                    push_exp("inc_to_ff_tc", 0, 8'hFF, MODE_INC, 1'b1, 1'b0);
                end
                3: push_exp("inc_wrap_ovf", 0, 8'h00, MODE_INC, 1'b0, 1'b1);
                default: push_exp("inc_after_wrap", 0, 8'h01, MODE_INC, 1'b0, 1'b0);
            endcase
            tick();
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); o = observe(e.d); n_tests++;
                if ({o.out, o.mode, o.tc, o.ovf} !== {e.out, e.mode, e.tc, e.ovf}) begin
                    n_fail++;
                    $display("FAIL %s: got out=%h mode=%0d tc=%b ovf=%b, want out=%h mode=%0d tc=%b ovf=%b",
                             e.name, o.out, o.mode, o.tc, o.ovf, e.out, e.mode, e.tc, e.ovf);
                end
            end
        end
    endtask

    task automatic test_dec_wrap();
        exp_t e, o;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(8'h00, MODE_LOAD, 1'b1, 1'b0);
                1: begin
                    drive(8'h01, MODE_DEC, 1'b1, 1'b1);
                    push_exp("dec_load", 0, 8'h01, MODE_DEC, 1'b0, 1'b0);
                end
                2: begin
                    drive(8'h00, MODE_DEC, 1'b0, 1'b1);
                    push_exp("dec_to_zero_tc", 0, 8'h00, MODE_DEC, 1'b1, 1'b0);
                end
                3: push_exp("dec_wrap_ovf", 0, 8'hFF, MODE_DEC, 1'b0, 1'b1);
                default: begin
                    drive(8'h00, MODE_DEC, 1'b0, 1'b0);
                    push_exp("dec_hold_en0", 0, 8'hFF, MODE_DEC, 1'b0, 1'b0);
                end
            endcase
            tick();
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); o = observe(e.d); n_tests++;
                if ({o.out, o.mode, o.tc, o.ovf} !== {e.out, e.mode, e.tc, e.ovf}) begin
                    n_fail++;
                    $display("FAIL %s: got out=%h mode=%0d tc=%b ovf=%b, want out=%h mode=%0d tc=%b ovf=%b",
                             e.name, o.out, o.mode, o.tc, o.ovf, e.out, e.mode, e.tc, e.ovf);
                end
            end
        end
    endtask

    task automatic test_saturate();
        exp_t e, o;
        for (int i = 0; i < 9; i++) begin
            case (i)
                0: drive(8'h00, MODE_LOAD, 1'b1, 1'b0);
                1: begin
                    drive(8'h04, MODE_DEC, 1'b1, 1'b1);
                    push_exp("sat_dec_load", 1, 8'h04, MODE_DEC, 1'b0, 1'b0);
                end
                2: begin
                    drive(8'h00, MODE_DEC, 1'b0, 1'b1);
                    push_exp("sat_dec_step3", 1, 8'h01, MODE_DEC, 1'b0, 1'b0);
                end
                3: push_exp("sat_dec_clamp", 1, 8'h00, MODE_DEC, 1'b1, 1'b1);
                4: push_exp("sat_dec_hold", 1, 8'h00, MODE_DEC, 1'b1, 1'b1);
                5: begin
                    drive(8'h00, MODE_LOAD, 1'b1, 1'b0);
                    push_exp("sat_to_load", 1, 8'h00, MODE_LOAD, 1'b0, 1'b0);
                end
                6: begin
                    drive(8'hFE, MODE_INC, 1'b1, 1'b1);
                    push_exp("sat_inc_load", 1, 8'hFE, MODE_INC, 1'b0, 1'b0);
                end
                7: begin
                    drive(8'h00, MODE_INC, 1'b0, 1'b1);
                    push_exp("sat_inc_clamp", 1, 8'hFF, MODE_INC, 1'b1, 1'b1);
                end
                default: push_exp("sat_inc_hold", 1, 8'hFF, MODE_INC, 1'b1, 1'b1);
            endcase
            tick();
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); o = observe(e.d); n_tests++;
                if ({o.out, o.mode, o.tc, o.ovf} !== {e.out, e.mode, e.tc, e.ovf}) begin
                    n_fail++;
                    $display("FAIL %s: got out=%h mode=%0d tc=%b ovf=%b, want out=%h mode=%0d tc=%b ovf=%b",
                             e.name, o.out, o.mode, o.tc, o.ovf, e.out, e.mode, e.tc, e.ovf);
                end
            end
        end
    endtask

    task automatic test_shift();
        exp_t e, o;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: drive(8'h00, MODE_LOAD, 1'b1, 1'b0);
                1: begin
                    drive(8'h81, MODE_SHIFT, 1'b1, 1'b1);
                    push_exp("shift_load_a", 0, 8'h81, MODE_SHIFT, 1'b0, 1'b0);
                    push_exp("shift_load_r", 2, 8'h81, MODE_SHIFT, 1'b0, 1'b0);
                end
                2: begin
                    drive(8'h01, MODE_SHIFT, 1'b0, 1'b1);
                    push_exp("shift_fill1_a", 0, 8'h03, MODE_SHIFT, 1'b0, 1'b1);
                    push_exp("rotate_msb_r", 2, 8'h03, MODE_SHIFT, 1'b0, 1'b0);
                end
                3: begin
                    drive(8'h00, MODE_SHIFT, 1'b0, 1'b1);
                    push_exp("shift_fill0_a", 0, 8'h06, MODE_SHIFT, 1'b0, 1'b0);
                    push_exp("rotate_second_r", 2, 8'h06, MODE_SHIFT, 1'b0, 1'b0);
                end
                4: drive(8'h00, MODE_LOAD, 1'b1, 1'b0);
                5: begin
                    drive(8'h80, MODE_SHIFT, 1'b1, 1'b1);
                    push_exp("shift_load80_r", 2, 8'h80, MODE_SHIFT, 1'b0, 1'b0);
                end
                default: begin
                    drive(8'h00, MODE_SHIFT, 1'b0, 1'b1);
                    push_exp("shift_msb_out_a", 0, 8'h00, MODE_SHIFT, 1'b0, 1'b1);
                    push_exp("rotate_msb_in_r", 2, 8'h01, MODE_SHIFT, 1'b0, 1'b0);
                end
            endcase
            tick();
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); o = observe(e.d); n_tests++;
                if ({o.out, o.mode, o.tc, o.ovf} !== {e.out, e.mode, e.tc, e.ovf}) begin
                    n_fail++;
                    $display("FAIL %s: got out=%h mode=%0d tc=%b ovf=%b, want out=%h mode=%0d tc=%b ovf=%b",
                             e.name, o.out, o.mode, o.tc, o.ovf, e.out, e.mode, e.tc, e.ovf);
                end
            end
        end
    endtask

    task automatic test_mode_en();
        exp_t e, o;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0: drive(8'h00, MODE_LOAD, 1'b1, 1'b0);
                1: begin
                    drive(8'h5A, MODE_INC, 1'b1, 1'b1);
                    push_exp("mode_load", 0, 8'h5A, MODE_INC, 1'b0, 1'b0);
                end
                2: begin
                    drive(8'hFF, MODE_DEC, 1'b1, 1'b0);
                    push_exp("mode_to_dec", 0, 8'h5A, MODE_DEC, 1'b0, 1'b0);
                end
                3: begin
                    drive(8'hFF, MODE_SHIFT, 1'b1, 1'b0);
                    push_exp("mode_to_shift", 0, 8'h5A, MODE_SHIFT, 1'b0, 1'b0);
                end
                4: begin
                    drive(8'hFF, MODE_LOAD, 1'b1, 1'b0);
                    push_exp("mode_to_load", 0, 8'h5A, MODE_LOAD, 1'b0, 1'b0);
                end
                5: begin
                    drive(8'hFF, MODE_INC, 1'b1, 1'b0);
                    push_exp("mode_to_inc", 0, 8'h5A, MODE_INC, 1'b0, 1'b0);
                end
                6: push_exp("mode_self_write", 0, 8'h5A, MODE_INC, 1'b0, 1'b0);
                default: begin
                    drive(8'hFF, MODE_DEC, 1'b0, 1'b0);
                    push_exp("mode_hold_no_wr", 0, 8'h5A, MODE_INC, 1'b0, 1'b0);
                end
            endcase
            tick();
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); o = observe(e.d); n_tests++;
                if ({o.out, o.mode, o.tc, o.ovf} !== {e.out, e.mode, e.tc, e.ovf}) begin
                    n_fail++;
                    $display("FAIL %s: got out=%h mode=%0d tc=%b ovf=%b, want out=%h mode=%0d tc=%b ovf=%b",
                             e.name, o.out, o.mode, o.tc, o.ovf, e.out, e.mode, e.tc, e.ovf);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_inc_wrap();
        test_dec_wrap();
        test_saturate();
        test_shift();
        test_mode_en();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
